// File: rtl/program_loader.sv
// Byte-stream loader: assembles framed bytes into 28-bit words, writes them to instruction
// memory from address 0, and releases the core reset only after the frame checksum passes.
//   state  | meaning
//   IDLE   | waiting for iStart after reset, core held in reset
//   LEN_LO | expecting low byte of the word count
//   LEN_HI | expecting high byte of the word count
//   DATA   | collecting b0..b3 of the current word
//   WRITE  | one-cycle write strobe for the assembled word
//   CHECK  | expecting the XOR checksum byte
//   DONE   | load good, core released
//   ERROR  | load aborted, core held in reset
module program_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 28
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStart,
    input  logic [7:0]             iByte,
    input  logic                   iByteValid,
    output logic                   oByteReady,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oCpuReset,
    output logic                   oDone,
    output logic                   oError
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t                  state, state_next;
    logic [7:0]              len_lo, len_lo_next;
    logic [ADDR_WIDTH:0]     remaining, remaining_next;
    logic [1:0]              byte_idx, byte_idx_next;
    logic [23:0]             word_buf, word_buf_next;
    logic [7:0]              checksum, checksum_next;
    logic [ADDR_WIDTH-1:0]   address_next;
    logic [INSTR_WIDTH-1:0]  instruction_next;
    logic [15:0]             len_full;
    logic                    accept;

    assign accept   = iByteValid && oByteReady;
    assign len_full = {iByte, len_lo};

    always_comb begin
        state_next       = state;
        len_lo_next      = len_lo;
        remaining_next   = remaining;
        byte_idx_next    = byte_idx;
        word_buf_next    = word_buf;
        checksum_next    = checksum;
        address_next     = oWriteAddress;
        instruction_next = oInstruction;

        case (state)
            IDLE, DONE, ERROR: begin
                if (iStart) begin
                    state_next    = LEN_LO;
                    checksum_next = 8'h00;
                    byte_idx_next = 2'd0;
                    address_next  = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_next   = iByte;
                    checksum_next = checksum ^ iByte;
                    state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    checksum_next = checksum ^ iByte;
                    if (len_full == 16'd0) begin
                        state_next = CHECK;
                    end else if (32'(len_full) > 32'(DEPTH)) begin
                        state_next = ERROR;
                    end else begin
                        remaining_next = (ADDR_WIDTH+1)'(len_full);
                        state_next     = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    checksum_next = checksum ^ iByte;
                    byte_idx_next = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_buf_next[7:0]   = iByte;
                        2'd1: word_buf_next[15:8]  = iByte;
                        2'd2: word_buf_next[23:16] = iByte;
                        default: begin
                            if (iByte[7:4] != 4'h0) begin
                                state_next = ERROR;
                            end else begin
                                instruction_next = {iByte[3:0], word_buf};
                                state_next       = WRITE;
                            end
                        end
                    endcase
                end
            end
            WRITE: begin
                address_next   = oWriteAddress + 1'b1;
                remaining_next = remaining - 1'b1;
                state_next     = (remaining == (ADDR_WIDTH+1)'(1)) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) begin
                    state_next = (iByte == checksum) ? DONE : ERROR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they settle one cycle after the causing edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state         <= IDLE;
            len_lo        <= 8'h00;
            remaining     <= '0;
            byte_idx      <= 2'd0;
            word_buf      <= 24'h0;
            checksum      <= 8'h00;
            oWriteAddress <= '0;
            oInstruction  <= '0;
            oByteReady    <= 1'b0;
            oWriteEnable  <= 1'b0;
            oCpuReset     <= 1'b1;
            oDone         <= 1'b0;
            oError        <= 1'b0;
        end else begin
            state         <= state_next;
            len_lo        <= len_lo_next;
            remaining     <= remaining_next;
            byte_idx      <= byte_idx_next;
            word_buf      <= word_buf_next;
            checksum      <= checksum_next;
            oWriteAddress <= address_next;
            oInstruction  <= instruction_next;
            oByteReady    <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
                             (state_next == DATA)   || (state_next == CHECK);
            oWriteEnable  <= (state_next == WRITE);
            oCpuReset     <= (state_next != DONE);
            oDone         <= (state_next == DONE);
            oError        <= (state_next == ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the stimulus and
// consumed by a monitor watching oWriteEnable.
module tb_program_loader;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iStart = 1'b0;
    logic [7:0]  iByte = 8'h00;
    logic        iByteValid = 1'b0;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [27:0] oInstruction;
    logic        oCpuReset;
    logic        oDone;
    logic        oError;

    int total = 0;
    int bad = 0;

    logic [35:0] exp_q[$];
    logic [7:0]  frame[$];

    program_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(28)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iByte(iByte),
        .iByteValid(iByteValid), .oByteReady(oByteReady), .oWriteEnable(oWriteEnable),
        .oWriteAddress(oWriteAddress), .oInstruction(oInstruction),
        .oCpuReset(oCpuReset), .oDone(oDone), .oError(oError)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge Clock);
            if (oWriteEnable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {oWriteAddress, oInstruction}, 36'h0);
                end else begin
                    check("write", {oWriteAddress, oInstruction}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic expect_write(input logic [7:0] addr, input logic [27:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            @(negedge Clock);
            iByteValid = 1'b0;
        end
        @(negedge Clock);
        iByte = b;
        iByteValid = 1'b1;
        while (!oByteReady && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (!oByteReady) check("byte_accept_timeout", 36'd0, 36'd1);
        else @(posedge Clock);
    endtask

    task automatic send_frame(input bit gap);
        foreach (frame[i]) send_byte(frame[i], gap);
        @(negedge Clock);
        iByteValid = 1'b0;
        frame.delete();
        @(negedge Clock);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        iByteValid = 1'b0;
        iStart = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic load_good_two();
        frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'h05, 8'h07, 8'h00, 8'h01, 8'h03, 8'h24};
        expect_write(8'h00, 28'h5001234);
        expect_write(8'h01, 28'h3010007);
    endtask

    initial begin
        logic [7:0] cs;
        logic [7:0] b0, b1, b2, b3;

        // Reset
        do_reset();
        check("rst_cpu_reset", oCpuReset, 1);
        check("rst_ready", oByteReady, 0);
        check("rst_we", oWriteEnable, 0);
        check("rst_done", oDone, 0);
        check("rst_error", oError, 0);
        check("rst_addr", oWriteAddress, 0);
        check("rst_instr", oInstruction, 0);
        repeat (5) @(negedge Clock);
        check("idle_hold", {oCpuReset, oByteReady, oDone, oError}, 4'b1000);

        // Good load, continuous valid
        pulse_start();
        check("ready_after_start", oByteReady, 1);
        load_good_two();
        send_frame(0);
        check("good_done", {oDone, oError, oCpuReset}, 3'b100);
        check("good_writes_all", exp_q.size(), 0);

        // Good load, valid toggling
        pulse_start();
        check("restart_cpu_reset", {oCpuReset, oDone}, 2'b10);
        load_good_two();
        send_frame(1);
        check("toggle_done", {oDone, oError, oCpuReset}, 3'b100);
        check("toggle_writes_all", exp_q.size(), 0);

        // Bad checksum, then recovery
        pulse_start();
        load_good_two();
        frame[10] = 8'h25;
        send_frame(0);
        check("badcs_error", {oDone, oError, oCpuReset}, 3'b011);
        check("badcs_writes_all", exp_q.size(), 0);
        pulse_start();
        check("badcs_restart_clear", {oError, oByteReady}, 2'b01);
        load_good_two();
        send_frame(0);
        check("recover_done", {oDone, oError, oCpuReset}, 3'b100);

        // Bad high nibble in b3: no write
        pulse_start();
        frame = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h00, 8'h15};
        send_frame(0);
        check("nibble_error", {oDone, oError, oCpuReset, oByteReady}, 4'b0110);
        repeat (3) @(negedge Clock);

        // Zero length
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("len0_done", {oDone, oError, oCpuReset}, 3'b100);

        // Length 0x0101 exceeds depth
        pulse_start();
        frame = '{8'h01, 8'h01};
        send_frame(0);
        check("len_over_error", {oDone, oError, oCpuReset, oByteReady}, 4'b0110);

        // Full depth: 256 words, last one at 0xFF
        pulse_start();
        frame = '{8'h00, 8'h01};
        cs = 8'h01;
        for (int i = 0; i < 256; i++) begin
            b0 = 8'(i);
            b1 = ~8'(i);
            b2 = 8'h5A;
            b3 = {4'h0, 4'(i)};
            frame.push_back(b0);
            frame.push_back(b1);
            frame.push_back(b2);
            frame.push_back(b3);
            cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
            expect_write(8'(i), {b3[3:0], b2, b1, b0});
        end
        frame.push_back(cs);
        send_frame(0);
        check("full_done", {oDone, oError, oCpuReset}, 3'b100);
        check("full_writes_all", exp_q.size(), 0);

        // Mid-operation reset after b1 of the second word
        pulse_start();
        frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'h05, 8'h07, 8'h00};
        expect_write(8'h00, 28'h5001234);
        foreach (frame[i]) send_byte(frame[i], 0);
        frame.delete();
        do_reset();
        @(negedge Clock);
        check("midrst_outputs", {oCpuReset, oByteReady, oWriteEnable, oDone, oError}, 5'b10000);
        check("midrst_addr_instr", {oWriteAddress, oInstruction}, 36'h0);
        repeat (6) @(negedge Clock);
        check("midrst_writes_all", exp_q.size(), 0);

        // New session with an ignored iStart during DATA
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        @(negedge Clock);
        iByteValid = 1'b0;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        check("start_ignored_ready", oByteReady, 1);
        expect_write(8'h00, 28'h5001234);
        expect_write(8'h01, 28'h3010007);
        frame = '{8'h12, 8'h00, 8'h05, 8'h07, 8'h00, 8'h01, 8'h03, 8'h24};
        send_frame(0);
        check("after_rst_done", {oDone, oError, oCpuReset}, 3'b100);
        check("after_rst_writes_all", exp_q.size(), 0);

        repeat (2) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that fills the instruction memory read by the MiniAlu core. It accepts a framed byte stream over a valid/ready handshake and assembles 28-bit instruction words. It writes the words to consecutive instruction-memory addresses starting at 0 and holds the core in reset until the whole frame has loaded and its checksum has passed. It is the writer side of the core's instruction-fetch read port.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory address width; program depth is 2^ADDR_WIDTH words.
- INSTR_WIDTH, 28, instruction word width; fixed at 28, the core's instruction format.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- iStart  in  1  single-cycle request to begin a load session.
- iByte  in  8  stream data byte.
- iByteValid  in  1  iByte is valid.
- oByteReady  out  1  loader can accept a byte. A byte transfers on an edge where iByteValid && oByteReady.
- oWriteEnable  out  1  instruction-memory write strobe.
- oWriteAddress  out  ADDR_WIDTH  write address.
- oInstruction  out  INSTR_WIDTH  write data.
- oCpuReset  out  1  active-high reset to the core.
- oDone  out  1  load completed and checksum matched.
- oError  out  1  load aborted.

## Operation
Frame format:
- LEN_LO, LEN_HI: word count N, 16-bit, little-endian.
- N words of 4 bytes each, b0 first.
- One checksum byte equal to the XOR of every preceding frame byte, length bytes included.
- Each word is assembled as oInstruction = {b3[3:0], b2, b1, b0}.
- b3[7:4] must be 0.

States and transitions:
- IDLE: oCpuReset=1, oByteReady=0. iStart → LEN_LO. This clears the checksum accumulator, the byte index, the write address and the oDone/oError flags.
- LEN_LO: ready=1; on accept, latch the low byte → LEN_HI.
- LEN_HI: ready=1; on accept, latch the high byte, then:
  - N == 0 → CHECK.
  - N > 2^ADDR_WIDTH → ERROR.
  - Otherwise → DATA.
- DATA: ready=1; accept b0..b3. After b3:
  - b3[7:4] != 0 → ERROR, with no write.
  - Otherwise → WRITE.
- WRITE: ready=0. oWriteEnable=1 for exactly this one cycle, carrying the current address and word. Then the address increments and the remaining-word count decrements. Remaining count 0 → CHECK; otherwise → DATA.
- CHECK: ready=1; accept one byte. Byte equals the accumulator → DONE; otherwise → ERROR.
- DONE: oDone=1, oCpuReset=0, ready=0.
- ERROR: oError=1, oCpuReset=1, ready=0.
- From DONE or ERROR, iStart → LEN_LO with the same clearing as IDLE. oCpuReset returns to 1 in the same transition.

Boundary rules:
- iStart is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHECK.
- The write address wraps only by reaching N = 2^ADDR_WIDTH exactly. The last write lands at address 2^ADDR_WIDTH-1.
- Words written before an ERROR stay in memory; there is no rollback.
- Reset asserted mid-session returns the block to IDLE with all outputs at their reset values. A partially assembled word is discarded.
- iByte is ignored whenever oByteReady=0.

## Timing
- Reset values: oCpuReset=1; oByteReady=0, oWriteEnable=0, oDone=0, oError=0; oWriteAddress=0, oInstruction=0.
- All outputs are registered.
- oByteReady rises in the cycle after the iStart edge.
- oWriteEnable is high in the cycle after the edge that accepts b3; memory samples it on the next edge.
- Peak throughput is 5 cycles per word with iByteValid held high.
- oDone, oError and oCpuReset change in the cycle after the checksum byte is accepted, or after the faulting byte.
- Backpressure (iByteValid low) stalls the FSM with no state change and no timeout.

## Test plan
- **Reset:** hold Reset=0 for 2 cycles → oCpuReset=1; oByteReady, oWriteEnable, oDone and oError all 0; no output changes without iStart.
- **Good load:**
  - Stimulus: iStart, then bytes 02 00 | 34 12 00 05 | 07 00 01 03 | 24.
  - Writes: exactly two pulses, addr 0 = 0x5001234 and addr 1 = 0x3010007.
  - End state: oDone=1, oCpuReset=0.
  - Repeat with iByteValid toggling every other cycle → same writes.
- **Bad checksum:** same frame with last byte 25 → both writes occur, oError=1, oCpuReset stays 1. iStart then a correct frame → oDone=1 and oError cleared.
- **Bad nibble:** 01 00 | 34 12 00 15 → ERROR right after b3, zero write pulses, oByteReady=0.
- **Length edges (ADDR_WIDTH=8):**
  - 00 00 00 → DONE with no writes.
  - 01 01 → ERROR after LEN_HI.
  - N = 0x0100 with a valid payload → last write at address 0xFF, then DONE.
- **Mid-op reset:** Reset=0 after b1 of word 1 → IDLE, oCpuReset=1, no further writes. iStart during DATA is ignored; a new session after reset loads correctly from address 0.
